brick_field: RTL and testbench

- Holds the alive/destroyed state of the Breakout brick wall.
- Answers per-pixel queries from the VGA raster (DrawX/DrawY) with brick_on/brick_border. The colour mapper consumes these directly, as a same-cycle combinational path.
- Services collision requests from ball motion logic through a four-phase req/ack handshake: clears hit bricks, tracks bricks remaining and score.

---
 rtl/breakout_pkg.sv | 20 ++
 rtl/brick_locate.sv | 40 ++++
 rtl/brick_field.sv | 147 ++++++++++++++
 tb/tb_brick_field.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared screen constants, brick-wall geometry defaults and the collision FSM
// state type for the Breakout brick field.
package breakout_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  localparam int BRICK_COLS   = 20;
  localparam int BRICK_ROWS   = 6;
  localparam int BRICK_WIDTH  = 32;
  localparam int BRICK_HEIGHT = 16;
  localparam int WALL_TOP     = 64;
  localparam int MORTAR       = 2;
  localparam int BRICK_POINTS = 10;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, ACK} hit_state_e;

endpackage

// File: rtl/brick_locate.sv
// Maps a screen point to its brick cell: in-field flag, row/col, flat index
// and whether the point sits on the cell's left/top mortar band.
module brick_locate
  import breakout_pkg::*;
#(
  parameter int COLS    = BRICK_COLS,
  parameter int ROWS    = BRICK_ROWS,
  parameter int BRICK_W = BRICK_WIDTH,
  parameter int BRICK_H = BRICK_HEIGHT,
  parameter int TOP_Y   = WALL_TOP,
  parameter int BORDER  = MORTAR,
  parameter int IDX_W   = $clog2(COLS*ROWS)
) (
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic             in_field,
  output logic [9:0]       row,
  output logic [9:0]       col,
  output logic [IDX_W-1:0] index,
  output logic             border
);

  localparam int XS = $clog2(BRICK_W);
  localparam int YS = $clog2(BRICK_H);

  logic [9:0]  dy;
  logic [15:0] idx_full;

  always_comb begin
    dy       = y - 10'(TOP_Y);
    col      = x >> XS;
    row      = dy >> YS;
    // y below TOP_Y wraps dy, so the explicit compare is what rejects it
    in_field = (y >= 10'(TOP_Y)) && (row < 10'(ROWS)) && (col < 10'(COLS));
    idx_full = 16'(row) * 16'(COLS) + 16'(col);
    index    = in_field ? idx_full[IDX_W-1:0] : '0;
    border   = (x[XS-1:0] < XS'(BORDER)) || (dy[YS-1:0] < YS'(BORDER));
  end

endmodule

// File: rtl/brick_field.sv
// Brick wall state: raster brick_on/brick_border lookup plus a req/ack
// collision engine that clears hit bricks and keeps count and score.
module brick_field
  import breakout_pkg::*;
#(
  parameter int COLS            = BRICK_COLS,
  parameter int ROWS            = BRICK_ROWS,
  parameter int BRICK_W         = BRICK_WIDTH,
  parameter int BRICK_H         = BRICK_HEIGHT,
  parameter int TOP_Y           = WALL_TOP,
  parameter int BORDER          = MORTAR,
  parameter int SCORE_PER_BRICK = BRICK_POINTS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        brick_on,
  output logic        brick_border,
  input  logic        hit_req,
  input  logic [9:0]  hit_x,
  input  logic [9:0]  hit_y,
  output logic        hit_ack,
  output logic        hit_brick,
  input  logic        restart,
  output logic [7:0]  bricks_left,
  output logic [15:0] score,
  output logic        level_clear
);

  localparam int NB    = ROWS*COLS;
  localparam int IDX_W = $clog2(NB);

  hit_state_e       state_q, state_d;
  logic [9:0]       hx_q, hx_d, hy_q, hy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [NB-1:0]    alive_q, alive_d;
  logic [7:0]       left_q, left_d;
  logic [15:0]      score_q, score_d;
  logic             lvl_q, lvl_d;
  logic [16:0]      score_sum;

  logic             r_in, q_in, r_border, q_border;
  logic [9:0]       r_row, r_col, q_row, q_col;
  logic [IDX_W-1:0] r_idx, q_idx;
  logic             unused_locate;

  brick_locate #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
    .TOP_Y(TOP_Y), .BORDER(BORDER), .IDX_W(IDX_W)
  ) u_raster (
    .x(DrawX), .y(DrawY), .in_field(r_in), .row(r_row), .col(r_col),
    .index(r_idx), .border(r_border)
  );

  brick_locate #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
    .TOP_Y(TOP_Y), .BORDER(BORDER), .IDX_W(IDX_W)
  ) u_query (
    .x(hx_q), .y(hy_q), .in_field(q_in), .row(q_row), .col(q_col),
    .index(q_idx), .border(q_border)
  );

  assign unused_locate = ^{r_row, r_col, q_row, q_col, q_border};

  assign brick_on     = r_in && alive_q[r_idx];
  assign brick_border = brick_on && r_border;
  assign hit_ack      = (state_q == ACK);
  assign hit_brick    = (state_q == ACK) && hit_q;
  assign bricks_left  = left_q;
  assign score        = score_q;
  assign level_clear  = lvl_q;

  always_comb begin
    state_d   = state_q;
    hx_d      = hx_q;
    hy_d      = hy_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    alive_d   = alive_q;
    left_d    = left_q;
    score_d   = score_q;
    score_sum = {1'b0, score_q} + 17'(SCORE_PER_BRICK);

    case (state_q)
      IDLE: if (hit_req) begin
        hx_d    = hit_x;
        hy_d    = hit_y;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        idx_d   = q_idx;
        hit_d   = q_in && alive_q[q_idx];
        state_d = UPDATE;
      end
      UPDATE: begin
        if (hit_q) begin
          alive_d[idx_q] = 1'b0;
          if (left_q != 8'd0) left_d = left_q - 8'd1;
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
        state_d = ACK;
      end
      ACK: if (!hit_req) begin
        hit_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Wall reload discards any in-flight query but keeps the score
    if (restart) begin
      alive_d = '1;
      left_d  = 8'(NB);
      hit_d   = 1'b0;
      state_d = IDLE;
    end

    lvl_d = (left_d == 8'd0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      hx_q    <= '0;
      hy_q    <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      alive_q <= '1;
      left_q  <= 8'(NB);
      score_q <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      alive_q <= alive_d;
      left_q  <= left_d;
      score_q <= score_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Scoreboarded bench for brick_field: directed raster probes and collision
// requests, with a monitor that checks each ack against queued expectations.
module tb_brick_field;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        brick_on, brick_border;
  logic        hit_req = 1'b0;
  logic [9:0]  hit_x = '0, hit_y = '0;
  logic        hit_ack, hit_brick;
  logic        restart = 1'b0;
  logic [7:0]  bricks_left;
  logic [15:0] score;
  logic        level_clear;

  brick_field dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .brick_on(brick_on), .brick_border(brick_border),
    .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ack(hit_ack), .hit_brick(hit_brick), .restart(restart),
    .bricks_left(bricks_left), .score(score), .level_clear(level_clear)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        hit;
    logic [7:0]  left;
    logic [15:0] score;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  m_left = 8'd120;
  logic [15:0] m_score = 16'd0;
  bit          mdl[6][20];
  logic        ack_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rising hit_ack consumes one scoreboard entry
  always @(negedge Clk) begin
    exp_t e;
    if (hit_ack && !ack_prev) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        chk("sb_hit_brick", 32'(hit_brick), 32'(e.hit));
        chk("sb_bricks_left", 32'(bricks_left), 32'(e.left));
        chk("sb_score", 32'(score), 32'(e.score));
      end
    end
    if (!hit_ack && !Reset) chk("hit_brick_without_ack", 32'(hit_brick), 0);
    ack_prev = hit_ack;
  end

  task automatic ras(input int x, input int y, input logic on, input logic bd);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    chk($sformatf("brick_on(%0d,%0d)", x, y), 32'(brick_on), 32'(on));
    chk($sformatf("brick_border(%0d,%0d)", x, y), 32'(brick_border), 32'(bd));
  endtask

  // Ack is expected after the third rising edge counting the sampling edge
  task automatic do_hit(input int x, input int y, input logic exp_hit, input int hold);
    exp_t e;
    int   n;
    if (exp_hit) begin
      m_left  = m_left - 8'd1;
      m_score = m_score + 16'd10;
    end
    e.hit = exp_hit; e.left = m_left; e.score = m_score;
    sb.push_back(e);
    @(negedge Clk);
    hit_x = 10'(x); hit_y = 10'(y); hit_req = 1'b1;
    for (n = 1; n <= 10; n++) begin
      @(posedge Clk); #1;
      if (hit_ack) break;
    end
    if (n > 10) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack within 10 edges, expected ack at edge 3");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk("ack_latency", 32'(n), 3);
    end
    repeat (hold) begin
      @(posedge Clk); #1;
      chk("ack_held", 32'(hit_ack), 1);
      chk("left_held", 32'(bricks_left), 32'(m_left));
    end
    @(negedge Clk);
    hit_req = 1'b0;
    @(posedge Clk); #1;
    chk("ack_drop", 32'(hit_ack), 0);
    chk("hit_brick_drop", 32'(hit_brick), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    exp_t e;
    foreach (mdl[r, c]) mdl[r][c] = 1'b1;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_bricks_left", 32'(bricks_left), 120);
    chk("rst_score", 32'(score), 0);
    chk("rst_level_clear", 32'(level_clear), 0);
    chk("rst_hit_ack", 32'(hit_ack), 0);
    @(negedge Clk);
    Reset = 1'b0;

    ras(40, 72, 1, 0);
    ras(32, 72, 1, 1);
    ras(40, 63, 0, 0);
    ras(40, 65, 1, 1);
    ras(40, 66, 1, 0);
    ras(0, 64, 1, 1);
    ras(639, 159, 1, 0);
    ras(639, 160, 0, 0);

    do_hit(40, 72, 1, 0);  mdl[0][1] = 1'b0;
    ras(40, 72, 0, 0);
    ras(32, 72, 0, 0);
    do_hit(40, 72, 0, 0);
    do_hit(5, 10, 0, 0);
    do_hit(100, 72, 1, 5); mdl[0][3] = 1'b0;

    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 20; c++) begin
        do_hit(c*32 + 8, 64 + r*16 + 8, mdl[r][c], 0);
        mdl[r][c] = 1'b0;
      end
    chk("empty_level_clear", 32'(level_clear), 1);
    chk("empty_bricks_left", 32'(bricks_left), 0);
    chk("empty_score", 32'(score), 1200);
    do_hit(8, 72, 0, 0);
    chk("empty_no_underflow", 32'(bricks_left), 0);

    @(negedge Clk); restart = 1'b1;
    @(posedge Clk); #1;
    chk("restart_bricks_left", 32'(bricks_left), 120);
    chk("restart_level_clear", 32'(level_clear), 0);
    chk("restart_score_kept", 32'(score), 1200);
    @(negedge Clk); restart = 1'b0;
    m_left = 8'd120;
    ras(40, 72, 1, 0);

    // Restart lands while the query is in LOOKUP
    @(negedge Clk); hit_x = 10'd40; hit_y = 10'd72; hit_req = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk); restart = 1'b1; hit_req = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk); restart = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (hit_ack) seen = 1'b1;
    end
    chk("restart_discards_ack", 32'(seen), 0);
    chk("restart_discards_clear", 32'(bricks_left), 120);
    ras(40, 72, 1, 0);

    // Async reset while sitting in ACK
    m_left = 8'd119; m_score = 16'd1210;
    e.hit = 1'b1; e.left = m_left; e.score = m_score;
    sb.push_back(e);
    @(negedge Clk); hit_x = 10'd40; hit_y = 10'd72; hit_req = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("ack_before_reset", 32'(hit_ack), 1);
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("reset_mid_ack_hit_ack", 32'(hit_ack), 0);
    chk("reset_mid_ack_score", 32'(score), 0);
    chk("reset_mid_ack_left", 32'(bricks_left), 120);
    hit_req = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    ras(40, 72, 1, 0);

    repeat (2) @(posedge Clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
